// File: rtl/rs_lsu_gen.sv
// Load/store reservation station: multi-port dispatch, writeback capture,
// age-matrix selection (oldest-ready or strict in-order), flushable held
// valid/ready issue register.

// Priority match of one source tag against all writeback channels.
module rs_lsu_gen_wb_match #(
  parameter int WB_CH  = 3,
  parameter int XLEN   = 64,
  parameter int PRF_AW = 6
) (
  input  logic [PRF_AW-1:0]            tag,
  input  logic [WB_CH-1:0]             wb_valid,
  input  logic [WB_CH-1:0][PRF_AW-1:0] wb_prd,
  input  logic [WB_CH-1:0][XLEN-1:0]   wb_data,
  output logic                         hit,
  output logic [XLEN-1:0]              data
);
  // Scan high to low so the lowest matching channel is the one that sticks.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int c = WB_CH - 1; c >= 0; c--) begin
      if (wb_valid[c] && wb_prd[c] == tag) begin
        hit  = 1'b1;
        data = wb_data[c];
      end
    end
  end
endmodule

module rs_lsu_gen #(
  parameter int RS_DEPTH   = 8,
  parameter int DISP_W     = 2,
  parameter int WB_CH      = 3,
  parameter int XLEN       = 64,
  parameter int PRF_AW     = 6,
  parameter int ROB_IW     = 5,
  parameter int IMM_LEN    = 32,
  parameter int OP_W       = 16,
  parameter int ORDER_MODE = 0,
  localparam int IW        = $clog2(RS_DEPTH),
  localparam int CW        = IW + 1,
  localparam int PKG_W     = ROB_IW + PRF_AW + 2 * XLEN + IMM_LEN + OP_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [DISP_W-1:0]                disp_valid_i,
  output logic [DISP_W-1:0]                disp_ready_o,
  input  logic [DISP_W-1:0][ROB_IW-1:0]    disp_rob_id_i,
  input  logic [DISP_W-1:0][PRF_AW-1:0]    disp_prd_i,
  input  logic [DISP_W-1:0][PRF_AW-1:0]    disp_prs1_i,
  input  logic [DISP_W-1:0][PRF_AW-1:0]    disp_prs2_i,
  input  logic [DISP_W-1:0]                disp_rs1_ready_i,
  input  logic [DISP_W-1:0]                disp_rs2_ready_i,
  input  logic [DISP_W-1:0][XLEN-1:0]      disp_data1_i,
  input  logic [DISP_W-1:0][XLEN-1:0]      disp_data2_i,
  input  logic [DISP_W-1:0][IMM_LEN-1:0]   disp_imm_i,
  input  logic [DISP_W-1:0][OP_W-1:0]      disp_op_i,
  input  logic [WB_CH-1:0]                 wb_valid_i,
  input  logic [WB_CH-1:0][PRF_AW-1:0]     wb_prd_i,
  input  logic [WB_CH-1:0][XLEN-1:0]       wb_data_i,
  output logic                             lsu_req_valid_o,
  input  logic                             lsu_ready_i,
  output logic [PKG_W-1:0]                 lsu_package_o,
  output logic [CW-1:0]                    occupancy_o
);

  logic [RS_DEPTH-1:0]                busy_q, r1_q, r2_q;
  logic [RS_DEPTH-1:0][ROB_IW-1:0]    rob_q;
  logic [RS_DEPTH-1:0][PRF_AW-1:0]    prd_q, prs1_q, prs2_q;
  logic [RS_DEPTH-1:0][XLEN-1:0]      d1_q, d2_q;
  logic [RS_DEPTH-1:0][IMM_LEN-1:0]   imm_q;
  logic [RS_DEPTH-1:0][OP_W-1:0]      op_q;
  // age_q[j][i] = 1: entry j is older than entry i
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  age_q, age_nxt;

  logic [RS_DEPTH-1:0]                ent_hit1, ent_hit2;
  logic [RS_DEPTH-1:0][XLEN-1:0]      ent_d1, ent_d2;
  logic [DISP_W-1:0]                  dsp_hit1, dsp_hit2, acc;
  logic [DISP_W-1:0][XLEN-1:0]        dsp_d1, dsp_d2;
  logic [DISP_W-1:0][IW-1:0]          alloc_idx;
  logic [CW-1:0]                      free_cnt, acc_cnt;
  logic [RS_DEPTH-1:0]                elig, sel;
  logic [IW-1:0]                      sel_idx;
  logic                               sel_any, load;
  logic                               out_vld_q;
  logic [PKG_W-1:0]                   pkg_q;
  logic [CW-1:0]                      occ_q;

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_ent
    rs_lsu_gen_wb_match #(.WB_CH(WB_CH), .XLEN(XLEN), .PRF_AW(PRF_AW)) u_m1 (
      .tag(prs1_q[i]), .wb_valid(wb_valid_i), .wb_prd(wb_prd_i), .wb_data(wb_data_i),
      .hit(ent_hit1[i]), .data(ent_d1[i]));
    rs_lsu_gen_wb_match #(.WB_CH(WB_CH), .XLEN(XLEN), .PRF_AW(PRF_AW)) u_m2 (
      .tag(prs2_q[i]), .wb_valid(wb_valid_i), .wb_prd(wb_prd_i), .wb_data(wb_data_i),
      .hit(ent_hit2[i]), .data(ent_d2[i]));
  end

  for (genvar k = 0; k < DISP_W; k++) begin : g_dsp
    rs_lsu_gen_wb_match #(.WB_CH(WB_CH), .XLEN(XLEN), .PRF_AW(PRF_AW)) u_m1 (
      .tag(disp_prs1_i[k]), .wb_valid(wb_valid_i), .wb_prd(wb_prd_i), .wb_data(wb_data_i),
      .hit(dsp_hit1[k]), .data(dsp_d1[k]));
    rs_lsu_gen_wb_match #(.WB_CH(WB_CH), .XLEN(XLEN), .PRF_AW(PRF_AW)) u_m2 (
      .tag(disp_prs2_i[k]), .wb_valid(wb_valid_i), .wb_prd(wb_prd_i), .wb_data(wb_data_i),
      .hit(dsp_hit2[k]), .data(dsp_d2[k]));
    // Readiness counts only entries free at cycle start; a same-cycle issue does not help.
    assign disp_ready_o[k] = free_cnt >= CW'(k + 1);
    assign acc[k]          = disp_valid_i[k] & disp_ready_o[k] & ~flush_i;
  end

  // Port k takes the k-th free entry in ascending index order.
  always_comb begin
    logic [CW-1:0] cnt;
    cnt       = '0;
    alloc_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy_q[i]) begin
        for (int k = 0; k < DISP_W; k++)
          if (cnt == CW'(k)) alloc_idx[k] = IW'(i);
        cnt = cnt + 1'b1;
      end
    end
    free_cnt = cnt;
  end

  // Count accepted dispatches for the occupancy counter.
  always_comb begin
    acc_cnt = '0;
    for (int k = 0; k < DISP_W; k++) acc_cnt = acc_cnt + CW'(acc[k]);
  end

  // New entry is younger than everything; processing ports in ascending
  // order makes a higher port younger than a lower port of the same cycle.
  always_comb begin
    age_nxt = age_q;
    for (int k = 0; k < DISP_W; k++) begin
      if (acc[k]) begin
        for (int j = 0; j < RS_DEPTH; j++) begin
          age_nxt[j][alloc_idx[k]] = 1'b1;
          age_nxt[alloc_idx[k]][j] = 1'b0;
        end
      end
    end
  end

  // Oldest eligible (mode 0) or oldest busy if eligible (mode 1).
  always_comb begin
    logic blk_e, blk_b;
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) elig[i] = busy_q[i] & r1_q[i] & r2_q[i];
    for (int i = 0; i < RS_DEPTH; i++) begin
      blk_e = 1'b0;
      blk_b = 1'b0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && age_q[j][i]) begin
          if (elig[j])   blk_e = 1'b1;
          if (busy_q[j]) blk_b = 1'b1;
        end
      end
      sel[i] = (ORDER_MODE != 0) ? (busy_q[i] & ~blk_b & elig[i]) : (elig[i] & ~blk_e);
    end
    for (int i = 0; i < RS_DEPTH; i++)
      if (sel[i]) sel_idx = IW'(i);
  end

  assign sel_any = |sel;
  assign load    = sel_any & (~out_vld_q | lsu_ready_i);

  // Entry state: wakeup capture, free on issue load, dispatch write.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i] && !r1_q[i] && ent_hit1[i]) begin
          r1_q[i] <= 1'b1;
          d1_q[i] <= ent_d1[i];
        end
        if (busy_q[i] && !r2_q[i] && ent_hit2[i]) begin
          r2_q[i] <= 1'b1;
          d2_q[i] <= ent_d2[i];
        end
      end
      if (load) busy_q[sel_idx] <= 1'b0;
      for (int k = 0; k < DISP_W; k++) begin
        if (acc[k]) begin
          busy_q[alloc_idx[k]] <= 1'b1;
          rob_q[alloc_idx[k]]  <= disp_rob_id_i[k];
          prd_q[alloc_idx[k]]  <= disp_prd_i[k];
          prs1_q[alloc_idx[k]] <= disp_prs1_i[k];
          prs2_q[alloc_idx[k]] <= disp_prs2_i[k];
          r1_q[alloc_idx[k]]   <= disp_rs1_ready_i[k] | dsp_hit1[k];
          r2_q[alloc_idx[k]]   <= disp_rs2_ready_i[k] | dsp_hit2[k];
          d1_q[alloc_idx[k]]   <= (disp_rs1_ready_i[k] || !dsp_hit1[k]) ? disp_data1_i[k] : dsp_d1[k];
          d2_q[alloc_idx[k]]   <= (disp_rs2_ready_i[k] || !dsp_hit2[k]) ? disp_data2_i[k] : dsp_d2[k];
          imm_q[alloc_idx[k]]  <= disp_imm_i[k];
          op_q[alloc_idx[k]]   <= disp_op_i[k];
        end
      end
    end
  end

  // Age matrix has no reset: rows/columns are rewritten on allocation and gated by busy.
  always_ff @(posedge clk) age_q <= age_nxt;

  // Issue register valid: set on load, cleared on fire without reload.
  always_ff @(posedge clk) begin
    if (rst || flush_i)   out_vld_q <= 1'b0;
    else if (load)        out_vld_q <= 1'b1;
    else if (lsu_ready_i) out_vld_q <= 1'b0;
  end

  // Issue payload, held while stalled.
  always_ff @(posedge clk) begin
    if (load)
      pkg_q <= {rob_q[sel_idx], prd_q[sel_idx], d1_q[sel_idx], d2_q[sel_idx],
                imm_q[sel_idx], op_q[sel_idx]};
  end

  // Busy-entry count tracked incrementally.
  always_ff @(posedge clk) begin
    if (rst || flush_i) occ_q <= '0;
    else                occ_q <= occ_q + acc_cnt - CW'(load);
  end

  assign lsu_req_valid_o = out_vld_q;
  assign lsu_package_o   = pkg_q;
  assign occupancy_o     = occ_q;

endmodule

// File: tb/tb_rs_lsu_gen.sv
// Scoreboard bench: two instances (oldest-ready and in-order) share stimulus;
// expected issue packages are queued per instance and checked by a monitor.
module tb_rs_lsu_gen;
  localparam int PW = 187;

  logic clk = 1'b0;
  logic rst, flush, lsu_ready;
  logic [1:0]        disp_valid, r1, r2;
  logic [1:0][4:0]   disp_rob;
  logic [1:0][5:0]   disp_prd, prs1, prs2;
  logic [1:0][63:0]  d1, d2;
  logic [1:0][31:0]  imm;
  logic [1:0][15:0]  op;
  logic [2:0]        wb_valid;
  logic [2:0][5:0]   wb_prd;
  logic [2:0][63:0]  wb_data;
  logic [1:0]        drdy0, drdy1;
  logic              vld0, vld1;
  logic [PW-1:0]     pkg0, pkg1;
  logic [3:0]        occ0, occ1;

  int vec = 0;
  int err = 0;
  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];

  always #5 clk = ~clk;

  rs_lsu_gen #(.ORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .disp_valid_i(disp_valid), .disp_ready_o(drdy0),
    .disp_rob_id_i(disp_rob), .disp_prd_i(disp_prd), .disp_prs1_i(prs1), .disp_prs2_i(prs2),
    .disp_rs1_ready_i(r1), .disp_rs2_ready_i(r2), .disp_data1_i(d1), .disp_data2_i(d2),
    .disp_imm_i(imm), .disp_op_i(op), .wb_valid_i(wb_valid), .wb_prd_i(wb_prd),
    .wb_data_i(wb_data), .lsu_req_valid_o(vld0), .lsu_ready_i(lsu_ready),
    .lsu_package_o(pkg0), .occupancy_o(occ0));

  rs_lsu_gen #(.ORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .disp_valid_i(disp_valid), .disp_ready_o(drdy1),
    .disp_rob_id_i(disp_rob), .disp_prd_i(disp_prd), .disp_prs1_i(prs1), .disp_prs2_i(prs2),
    .disp_rs1_ready_i(r1), .disp_rs2_ready_i(r2), .disp_data1_i(d1), .disp_data2_i(d2),
    .disp_imm_i(imm), .disp_op_i(op), .wb_valid_i(wb_valid), .wb_prd_i(wb_prd),
    .wb_data_i(wb_data), .lsu_req_valid_o(vld1), .lsu_ready_i(lsu_ready),
    .lsu_package_o(pkg1), .occupancy_o(occ1));

  function automatic logic [PW-1:0] mk(input logic [4:0] rob, input logic [63:0] a, input logic [63:0] b);
    return {rob, {1'b1, rob}, a, b, 32'hA5A5_0000 ^ {27'h0, rob}, 16'h0100 + {11'h0, rob}};
  endfunction

  task automatic disp(input int k, input logic [4:0] rob, input logic [5:0] s1, input logic rd1,
                      input logic [63:0] v1, input logic [5:0] s2, input logic rd2, input logic [63:0] v2);
    disp_valid[k] = 1'b1;
    disp_rob[k]   = rob;
    disp_prd[k]   = {1'b1, rob};
    prs1[k] = s1; r1[k] = rd1; d1[k] = v1;
    prs2[k] = s2; r2[k] = rd2; d2[k] = v2;
    imm[k]  = 32'hA5A5_0000 ^ {27'h0, rob};
    op[k]   = 16'h0100 + {11'h0, rob};
  endtask

  task automatic rdy(input int k, input logic [4:0] rob, input logic [63:0] v1, input logic [63:0] v2);
    disp(k, rob, 6'd0, 1'b1, v1, 6'd0, 1'b1, v2);
  endtask

  task automatic wb(input int c, input logic [5:0] tag, input logic [63:0] v);
    wb_valid[c] = 1'b1; wb_prd[c] = tag; wb_data[c] = v;
  endtask

  task automatic push(input logic [PW-1:0] p);
    q0.push_back(p);
    q1.push_back(p);
  endtask

  // Apply current inputs across one edge, then return to idle inputs.
  task automatic cyc();
    @(posedge clk); #1;
    disp_valid = '0; wb_valid = '0; flush = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: whenever valid, payload must equal the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld0) begin
        vec++;
        if (q0.size() == 0) begin
          err++; $display("FAIL m0_unexpected: got %0h expected none", pkg0);
        end else begin
          if (pkg0 !== q0[0]) begin
            err++; $display("FAIL m0_pkg: got %0h expected %0h", pkg0, q0[0]);
          end
          if (lsu_ready) void'(q0.pop_front());
        end
      end
      if (vld1) begin
        vec++;
        if (q1.size() == 0) begin
          err++; $display("FAIL m1_unexpected: got %0h expected none", pkg1);
        end else begin
          if (pkg1 !== q1[0]) begin
            err++; $display("FAIL m1_pkg: got %0h expected %0h", pkg1, q1[0]);
          end
          if (lsu_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; lsu_ready = 1'b1;
    disp_valid = '0; disp_rob = '0; disp_prd = '0; prs1 = '0; prs2 = '0;
    r1 = '0; r2 = '0; d1 = '0; d2 = '0; imm = '0; op = '0;
    wb_valid = '0; wb_prd = '0; wb_data = '0;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_vld0", vld0, 0); chk("rst_vld1", vld1, 0);
    chk("rst_occ0", occ0, 0); chk("rst_occ1", occ1, 0);
    chk("rst_drdy0", drdy0, 2'b11); chk("rst_drdy1", drdy1, 2'b11);

    // 1: two ready ops in one cycle
    rdy(0, 5'd3, 64'h33, 64'h3); rdy(1, 5'd4, 64'h44, 64'h4);
    push(mk(5'd3, 64'h33, 64'h3)); push(mk(5'd4, 64'h44, 64'h4));
    cyc(); chk("t1_occ_t1", occ0, 2); chk("t1_vld_t1", vld0, 0);
    cyc(); chk("t1_occ_t2", occ0, 1); chk("t1_vld_t2", vld0, 1);
    cyc(); chk("t1_occ_t3", occ0, 0); chk("t1_occ1_t3", occ1, 0);
    repeat (3) cyc();

    // 2: same-cycle wakeup at dispatch, lowest channel wins
    disp(0, 5'd7, 6'd12, 1'b0, 64'h1111, 6'd0, 1'b1, 64'h22);
    wb(0, 6'd12, 64'hDEAD); wb(1, 6'd12, 64'hBEEF);
    push(mk(5'd7, 64'hDEAD, 64'h22));
    cyc(); chk("t2_vld_t1", vld0, 0);
    cyc(); chk("t2_vld_t2", vld0, 1); chk("t2_vld1_t2", vld1, 1);
    repeat (3) cyc();

    // 3: older blocked op vs younger ready op
    disp(0, 5'd1, 6'd5, 1'b0, 64'h0, 6'd0, 1'b1, 64'h11);
    rdy(1, 5'd2, 64'h2, 64'h22);
    q0.push_back(mk(5'd2, 64'h2, 64'h22)); q0.push_back(mk(5'd1, 64'h55, 64'h11));
    q1.push_back(mk(5'd1, 64'h55, 64'h11)); q1.push_back(mk(5'd2, 64'h2, 64'h22));
    cyc(); cyc();
    chk("t3_m0_vld", vld0, 1); chk("t3_m1_vld", vld1, 0);
    repeat (3) cyc();
    chk("t3_m1_hold", vld1, 0); chk("t3_m1_occ", occ1, 2); chk("t3_m0_occ", occ0, 1);
    wb(2, 6'd5, 64'h55);
    cyc(); cyc();
    chk("t3_m1_vld_wb", vld1, 1);
    repeat (4) cyc();

    // 4: fill all entries, then free one
    for (int c = 0; c < 4; c++) begin
      disp(0, 5'(8 + 2 * c), 6'd40, 1'b0, 64'h0, 6'd0, 1'b1, 64'(c));
      disp(1, 5'(9 + 2 * c), 6'd40, 1'b0, 64'h0, 6'd0, 1'b1, 64'(c + 16));
      cyc();
    end
    for (int c = 0; c < 4; c++) begin
      push(mk(5'(8 + 2 * c), 64'h40, 64'(c)));
      push(mk(5'(9 + 2 * c), 64'h40, 64'(c + 16)));
    end
    chk("t4_full_drdy", drdy0, 2'b00); chk("t4_full_occ", occ0, 8);
    wb(1, 6'd40, 64'h40);
    cyc(); chk("t4_wake_drdy", drdy0, 2'b00);
    cyc(); chk("t4_one_free", drdy0, 2'b01); chk("t4_one_free1", drdy1, 2'b01);
    chk("t4_occ7", occ0, 7);
    cyc(); chk("t4_two_free", drdy0, 2'b11);
    repeat (10) cyc();

    // 5: back-pressure hold
    lsu_ready = 1'b0;
    rdy(0, 5'd20, 64'h20, 64'h200); rdy(1, 5'd21, 64'h21, 64'h210);
    push(mk(5'd20, 64'h20, 64'h200)); push(mk(5'd21, 64'h21, 64'h210));
    cyc(); chk("t5_occ2", occ0, 2);
    cyc(); chk("t5_vld", vld0, 1);
    for (int c = 0; c < 5; c++) begin
      cyc(); chk("t5_hold_occ", occ0, 1); chk("t5_hold_vld", vld0, 1);
    end
    lsu_ready = 1'b1;
    cyc(); lsu_ready = 1'b0;
    chk("t5_one_fire", q0.size(), 1); chk("t5_occ0", occ0, 0);
    cyc(); cyc();
    lsu_ready = 1'b1;
    cyc(); chk("t5_drained", q0.size(), 0);
    repeat (2) cyc();

    // 6: flush with busy entries, valid output and a same-cycle dispatch
    lsu_ready = 1'b0;
    push(mk(5'd24, 64'h24, 64'h0));
    rdy(0, 5'd24, 64'h24, 64'h0); rdy(1, 5'd25, 64'h25, 64'h0); cyc();
    rdy(0, 5'd26, 64'h26, 64'h0); rdy(1, 5'd27, 64'h27, 64'h0); cyc();
    rdy(0, 5'd28, 64'h28, 64'h0); cyc();
    chk("t6_occ4", occ0, 4); chk("t6_vld", vld0, 1);
    flush = 1'b1; rdy(0, 5'd29, 64'h29, 64'h0);
    cyc();
    q0.delete(); q1.delete();
    chk("t6_vld0", vld0, 0); chk("t6_occ0", occ0, 0); chk("t6_drdy", drdy0, 2'b11);
    chk("t6_vld1", vld1, 0); chk("t6_occ1", occ1, 0);
    lsu_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(); chk("t6_absent", vld0, 0); chk("t6_occ_stay", occ0, 0);
    end

    // post-flush sanity issue
    rdy(1, 5'd30, 64'h30, 64'h31);
    push(mk(5'd30, 64'h30, 64'h31));
    cyc();
    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) cyc();
    chk("drain_q0", q0.size(), 0); chk("drain_q1", q1.size(), 0);
    chk("end_occ0", occ0, 0); chk("end_occ1", occ1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
